oscillator_period_ctl: RTL



---
 rtl/oscillator_period_ctl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/oscillator_period_ctl.sv
// Period control for the NCO: clamps accepted targets, then slews PERIOD_OUT toward
// the target with a divided-rate first-order smoother and reports when it has settled.
module oscillator_period_ctl #(
    parameter int              PERIOD_INT_PART  = 10,
    parameter int              PERIOD_FRAC_PART = 20,
    parameter int              SMOOTH_SHIFT     = 4,
    parameter int              UPDATE_DIV       = 16,
    parameter longint unsigned DEFAULT_PERIOD   = 64'h0640_0000,
    parameter longint unsigned SETTLE_TOL       = 64'h0000_1000,
    parameter int              SETTLE_TICKS     = 8
) (
    input  logic                                      CLK,
    input  logic                                      RESET_N,
    input  logic                                      CE,
    input  logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] TARGET_IN,
    input  logic                                      TARGET_VALID,
    output logic                                      TARGET_READY,
    input  logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] MIN_PERIOD,
    input  logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] MAX_PERIOD,
    output logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] PERIOD_OUT,
    output logic                                      SETTLED
);

    localparam int W  = PERIOD_INT_PART + PERIOD_FRAC_PART;
    localparam int PW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam int CW = $clog2(SETTLE_TICKS + 1);

    localparam logic [W-1:0]  DEF_PERIOD = W'(DEFAULT_PERIOD);
    localparam logic [W:0]    TOL        = (W+1)'(SETTLE_TOL);
    localparam logic [PW-1:0] PRESC_LAST = PW'(UPDATE_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(SETTLE_TICKS);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_TRACK,
        ST_SETTLED
    } state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    period_reg, period_next;
    logic [W-1:0]    active_reg, active_next;
    logic [W-1:0]    pending_reg, pending_next;
    logic            pending_full_reg, pending_full_next;
    logic            ready_reg, ready_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [CW-1:0]   settle_cnt_reg, settle_cnt_next;

    logic            tick;
    logic            accept;
    logic [W-1:0]    floor_clamped;
    logic [W-1:0]    clamped;
    logic [W-1:0]    eff_target;
    logic signed [W:0] diff;
    logic signed [W:0] shifted;
    logic signed [W:0] delta;
    logic [W:0]      mag;
    logic            in_tol;
    logic [W-1:0]    stepped;
    logic [CW-1:0]   cnt_inc;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_reg        <= ST_INIT;
            period_reg       <= DEF_PERIOD;
            active_reg       <= DEF_PERIOD;
            pending_reg      <= '0;
            pending_full_reg <= 1'b0;
            ready_reg        <= 1'b0;
            presc_reg        <= '0;
            settle_cnt_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            period_reg       <= period_next;
            active_reg       <= active_next;
            pending_reg      <= pending_next;
            pending_full_reg <= pending_full_next;
            ready_reg        <= ready_next;
            presc_reg        <= presc_next;
            settle_cnt_reg   <= settle_cnt_next;
        end
    end

    // Datapath terms; the step is computed from the pre-update output every cycle
    // and only committed on a tick.
    always_comb begin
        tick          = CE && (presc_reg == PRESC_LAST);
        accept        = TARGET_VALID && ready_reg;
        floor_clamped = (TARGET_IN < MIN_PERIOD) ? MIN_PERIOD : TARGET_IN;
        clamped       = (floor_clamped > MAX_PERIOD) ? MAX_PERIOD : floor_clamped;
        eff_target    = pending_full_reg ? pending_reg : active_reg;
        diff          = $signed({1'b0, eff_target}) - $signed({1'b0, period_reg});
        shifted       = diff >>> SMOOTH_SHIFT;
        delta         = shifted;
        if ((shifted == '0) && (diff != '0)) begin
            delta = diff[W] ? '1 : (W+1)'(1);
        end
        mag     = diff[W] ? (W+1)'(-diff) : diff;
        in_tol  = (mag <= TOL);
        stepped = period_reg + delta[W-1:0];
        cnt_inc = settle_cnt_reg + CW'(1);
    end

    always_comb begin
        state_next        = state_reg;
        period_next       = period_reg;
        active_next       = active_reg;
        pending_next      = pending_reg;
        pending_full_next = pending_full_reg;
        presc_next        = presc_reg;
        settle_cnt_next   = settle_cnt_reg;

        if (CE) begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
        end

        if (tick) begin
            if (pending_full_reg) begin
                active_next       = pending_reg;
                pending_full_next = 1'b0;
            end
            case (state_reg)
                ST_INIT: begin
                    if (pending_full_reg) begin
                        period_next     = pending_reg;
                        settle_cnt_next = '0;
                        state_next      = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    period_next = stepped;
                    if (in_tol) begin
                        settle_cnt_next = cnt_inc;
                        if (cnt_inc >= CNT_DONE) begin
                            state_next = ST_SETTLED;
                        end
                    end else begin
                        settle_cnt_next = '0;
                    end
                end
                ST_SETTLED: begin
                    period_next = stepped;
                    if (!in_tol) begin
                        settle_cnt_next = '0;
                        state_next      = ST_TRACK;
                    end
                end
                default: state_next = ST_INIT;
            endcase
        end

        // A drained slot can only refill here when READY was already high.
        if (accept) begin
            pending_next      = clamped;
            pending_full_next = 1'b1;
        end

        ready_next = !pending_full_next;
    end

    assign PERIOD_OUT   = period_reg;
    assign SETTLED      = (state_reg == ST_SETTLED);
    assign TARGET_READY = ready_reg;

endmodule
